// File: rtl/hwag_div_arbiter.sv
// rtl/hwag_div_arbiter.sv - round-robin arbiter/sequencer sharing one integer divider
module hwag_div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divider,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic [WIDTH-1:0]       remainder,
  output logic                   err,
  output logic                   busy,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divider,
  input  logic [WIDTH-1:0]       div_result,
  input  logic [WIDTH-1:0]       div_remainder,
  input  logic                   div_rdy
);

  localparam int              PW       = $clog2(N_REQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(N_REQ - 1);
  // WAIT cycle in which the counter reaches TIMEOUT after its increment
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [PW-1:0]    pick;
  logic             found;
  logic [PW:0]      idx;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: circular pick from ptr, divide-by-zero screen, wait/timeout, completion
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pick    = '0;
    found   = 1'b0;
    idx     = '0;

    // Scan from the farthest offset down so the nearest requester at/after ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d = pick;
          dvd_d = req_dividend[int'(pick)*WIDTH +: WIDTH];
          dvs_d = req_divider[int'(pick)*WIDTH +: WIDTH];
          if (dvs_d == '0) begin
            // Never hand a zero divisor to the core; complete immediately
            res_d   = '1;
            rem_d   = dvd_d;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (div_rdy) begin
          // A ready core beats the timeout limit in the same cycle
          res_d   = div_result;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          res_d   = '1;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ack and err only pulse in DONE
  always_comb begin
    ack = '0;
    if (state_q == S_DONE) ack[gnt_q] = 1'b1;
    err          = (state_q == S_DONE) && err_q;
    busy         = (state_q != S_IDLE);
    div_start    = (state_q == S_ISSUE);
    div_dividend = dvd_q;
    div_divider  = dvs_q;
    result       = res_q;
    remainder    = rem_q;
  end

endmodule

// File: tb/tb_hwag_div_arbiter.sv
// tb/tb_hwag_div_arbiter.sv - randomized self-checking bench for hwag_div_arbiter
module tb_hwag_div_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divider = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic [W-1:0]   remainder;
  logic           err;
  logic           busy;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divider;
  logic [W-1:0]   div_result = '0;
  logic [W-1:0]   div_remainder = '0;
  logic           div_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int d_cfg = 0;
  int left = 0;
  int ptr_m = 0;
  int rearm = -1;
  int last_gnt = -1;
  int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
  logic [W-1:0] mq = '0;
  logic [W-1:0] mr = '0;

  hwag_div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_dividend(req_dividend), .req_divider(req_divider),
    .ack(ack), .result(result), .remainder(remainder), .err(err), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divider(div_divider),
    .div_result(div_result), .div_remainder(div_remainder), .div_rdy(div_rdy)
  );

  always #5 clk = ~clk;

  // Divider model: rdy pulses d_cfg cycles after the start cycle; d_cfg==0 hangs
  always begin
    @(posedge clk);
    #2;
    div_rdy = 1'b0;
    if (left > 0) begin
      left--;
      if (left == 0) begin
        div_rdy       = 1'b1;
        div_result    = mq;
        div_remainder = mr;
      end
    end
    if (div_start) begin
      left = d_cfg;
      if (div_divider != '0) begin
        mq = div_dividend / div_divider;
        mr = div_dividend % div_divider;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divider[i*W +: W]  = b;
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++)
      if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // Called in an IDLE cycle with at least one req high; returns in the IDLE cycle after ack
  task automatic serve(input int dcfg);
    int idx, lat, n, gi;
    logic [W-1:0] a, b, er, erem;
    logic ee, got;
    idx = rr_pick();
    if (idx < 0) idx = 0;
    a = req_dividend[idx*W +: W];
    b = req_divider[idx*W +: W];
    if (b == '0) begin
      lat = 1; er = '1; erem = a; ee = 1'b1;
    end else if (dcfg >= 1 && dcfg <= T) begin
      lat = dcfg + 2; er = a / b; erem = a % b; ee = 1'b0;
    end else begin
      lat = T + 2; er = '1; erem = '0; ee = 1'b1;
    end
    d_cfg = dcfg;
    n = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      step();
      n++;
      if (n == 1) begin
        check_eq("div_start", div_start, (b != '0));
        if (rearm >= 0) begin
          req[rearm] = 1'b1;
          rearm = -1;
        end
      end
      if (ack != '0) got = 1'b1;
    end
    check_eq("latency", n, lat);
    check_eq("ack", ack, 64'(1) << idx);
    check_eq("result", result, er);
    check_eq("remainder", remainder, erem);
    check_eq("err", err, ee);
    check_eq("busy_done", busy, 1'b1);
    gi = -1;
    for (int i = 0; i < N; i++) if (ack[i]) gi = i;
    last_gnt = gi;
    req[idx] = 1'b0;
    ptr_m = (idx + 1) % N;
    step();
    check_eq("ack_clear", ack, 0);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("result_hold", result, er);
    check_eq("rem_hold", remainder, erem);
  endtask

  initial begin
    logic quiet;
    int dsel, dd;
    logic [W-1:0] a, b;

    do_reset();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_rem", remainder, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", div_start, 0);
    check_eq("rst_dvd", div_dividend, 0);
    check_eq("rst_dvs", div_divider, 0);

    // Single request
    set_op(2, 32'd39483, 32'd321);
    serve(4);

    // Divide by zero
    set_op(0, 32'd1000, 32'd0);
    serve(4);

    // Round robin with all requesters busy from reset
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom_range(1, 5000));
    for (int k = 0; k < 6; k++) begin
      rearm = (k > 0) ? last_gnt : -1;
      serve($urandom_range(2, 6));
      check_eq("rr_order", last_gnt, rr_seq[k]);
    end
    do_reset();

    // Hung divider, then a working one
    set_op(1, 32'd777, 32'd5);
    serve(0);
    set_op(2, 32'd12345, 32'd67);
    serve(3);

    // Reset two cycles after div_start
    set_op(3, 32'd5000, 32'd7);
    d_cfg = 6;
    step();
    check_eq("mid_start", div_start, 1'b1);
    step();
    step();
    rst = 1'b1;
    req = '0;
    step();
    check_eq("mid_ack", ack, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_result", result, 0);
    check_eq("mid_rem", remainder, 0);
    check_eq("mid_err", err, 0);
    check_eq("mid_start0", div_start, 0);
    check_eq("mid_dvd", div_dividend, 0);
    check_eq("mid_dvs", div_divider, 0);
    rst = 1'b0;
    ptr_m = 0;
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ack != '0 || busy) quiet = 1'b0;
    end
    check_eq("stale_rdy_ignored", quiet, 1'b1);
    set_op(0, 32'd81, 32'd9);
    set_op(3, 32'd100, 32'd7);
    serve(3);
    check_eq("post_rst_gnt", last_gnt, 0);
    serve(5);

    // div_rdy in the same cycle as the timeout limit
    set_op(1, 32'd4242, 32'd11);
    serve(T);

    // Randomized mix of requests, zero divisors, delays, timeouts
    for (int op = 0; op < 30; op++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) != 0) begin
          a = $urandom;
          b = ($urandom_range(0, 7) == 0) ? 32'd0 :
              (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom));
          set_op(i, a, b);
        end
      end
      if (req == '0) set_op($urandom_range(0, N - 1), $urandom, 32'($urandom_range(1, 99)));
      dsel = $urandom_range(0, 9);
      if (dsel == 0) dd = 0;
      else if (dsel == 1) dd = T + 1;
      else if (dsel == 2) dd = T;
      else dd = $urandom_range(2, 7);
      serve(dd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_div_arbiter.md
# hwag_div_arbiter

Round-robin arbiter and sequencer that shares the single `integer_div` core among up to `N_REQ` requesters in the angle-generator design, such as period→angle-step scaling and RPM calculation. It grants one requester at a time and drives the divider's start/operand pins. It then captures the quotient and remainder and returns them on a shared result bus with a per-requester one-cycle ack. It also screens division by zero and a hung divider, so a requester never stalls.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand/result width
- `TIMEOUT`, 255, max cycles spent in WAIT before aborting (1..2^16-1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req`  in  N_REQ  per-requester request level
- `req_dividend`  in  N_REQ*WIDTH  flattened; requester i at [i*WIDTH +: WIDTH]
- `req_divider`  in  N_REQ*WIDTH  flattened, same packing
- `ack`  out  N_REQ  one-hot one-cycle completion pulse
- `result`  out  WIDTH  quotient, valid while ack≠0, held until next completion
- `remainder`  out  WIDTH  remainder, same validity
- `err`  out  1  high with ack when the completion was divide-by-zero or timeout
- `busy`  out  1  high in every state except IDLE
- `div_start`  out  1  one-cycle start pulse to divider
- `div_dividend`  out  WIDTH  registered operand to divider
- `div_divider`  out  WIDTH  registered operand to divider
- `div_result`  in  WIDTH  divider quotient
- `div_remainder`  in  WIDTH  divider remainder
- `div_rdy`  in  1  divider done; contract: low in the cycle after div_start, high when outputs valid

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req` bit is high, pick the first requester at or after `ptr` (circular); register `gnt` and latch its operands into `div_dividend`/`div_divider`.
  - If the latched divider is 0: go to DONE with `err`=1, `result`=all ones, `remainder`=dividend.
  - Otherwise go to ISSUE.
- ISSUE: `div_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On `div_rdy`=1: capture `div_result`/`div_remainder`, `err`=0, go to DONE.
  - Else, if the counter reaches `TIMEOUT`: `result`=all ones, `remainder`=0, `err`=1, go to DONE.
  - `div_rdy` and `div_rdy` coinciding with the timeout limit: `div_rdy` wins.
- DONE: `ack[gnt]`=1 for this single cycle; `ptr` ← gnt+1 (mod N_REQ); go to IDLE.
- Requester rules:
  - Operands are held stable from req rise until ack.
  - `req` must be low in the cycle after ack; a registered requester clears it on the ack edge.
  - A req still high in that cycle is treated as a new request.
- `req` deasserted after grant, before ack: the operation still completes and ack still pulses; the requester ignores it.
- `div_rdy` outside WAIT is ignored.
- Quotient and remainder pass through unmodified; no width conversion.

## Timing
- Reset (sync): state=IDLE, `ptr`=0, `ack`=0, `result`=0, `remainder`=0, `err`=0, `busy`=0, `div_start`=0, `div_dividend`=0, `div_divider`=0, timeout counter=0.
- Reset asserted mid-operation: the in-flight divider result is discarded and no ack is issued.
- Latency, cycle 0 = first IDLE cycle with req sampled high: ISSUE in cycle 1.
  - If the divider raises `div_rdy` D cycles after the ISSUE cycle (D≥1), ack is in cycle D+2.
  - Divide-by-zero: ack in cycle 1.
  - Timeout: ack in cycle TIMEOUT+2.
- Back-to-back: the next grant is sampled in the IDLE cycle after DONE. Minimum spacing between acks is D+3 cycles.
- Fairness: a continuously requesting requester waits at most N_REQ-1 completions.

## Test plan
- Single request: divider model with D=4; requester 2 asks 39483/321 → `div_start` pulses in cycle 1, `ack`=4'b0100 in cycle 6, `result`=123, `remainder`=0, `err`=0.
- Divide by zero: requester 0 asks 1000/0 → no `div_start`; `ack[0]` in cycle 1; `result`=32'hFFFFFFFF, `remainder`=1000, `err`=1.
- Round robin: all 4 req held high from reset, each dropping req after its ack and re-raising it 1 cycle later → grant order 0,1,2,3,0,1 with no requester served twice in a row.
- Timeout: TIMEOUT=8, divider never raises rdy → `ack` 10 cycles after sampling, `err`=1, `result`=all ones, `remainder`=0. The next request with a working divider completes normally.
- Reset mid-WAIT: assert `rst` 2 cycles after `div_start` → next cycle all outputs at reset values, no ack; a later `div_rdy` pulse is ignored. A subsequent request is granted to the lowest index (ptr=0).
- Simultaneous `div_rdy` and timeout limit in the same cycle → `err`=0, captured divider result returned.
